// File: rtl/cmsdk_ahb_bm_input_stage_si1.sv
// AHB bus-matrix input stage for SI1: holds a stalled address phase until the decoder grants it.
// Optional build macro AHB_BM_SEQ2NONSEQ_EN re-issues a held SEQ transfer as NONSEQ/INCR.
module cmsdk_ahb_bm_input_stage_si1 #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HREADYS,
  input  logic                  active_in,
  input  logic                  readyout_in,
  input  logic [1:0]            resp_in,
  output logic                  sel_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [1:0]            trans_in,
  output logic                  write_in,
  output logic [2:0]            size_in,
  output logic [2:0]            burst_in,
  output logic [3:0]            prot_in,
  output logic                  held_tran,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS
);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;
  localparam logic [2:0] BST_INCR   = 3'b001;
  localparam logic [1:0] RSP_OKAY   = 2'b00;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_trans;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [2:0]            r_burst;
  logic [3:0]            r_prot;
  logic                  w_trans_req;
  logic [1:0]            w_held_trans;
  logic [2:0]            w_held_burst;

  assign w_trans_req = HSELS & HTRANSS[1] & HREADYS;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the holding register is reset too; it is a handful of flops, not a memory, and
  // a known value keeps the outputs deterministic straight out of reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_trans <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
    end else if (w_trans_req) begin
      r_addr  <= HADDRS;
      r_trans <= HTRANSS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_burst <= HBURSTS;
      r_prot  <= HPROTS;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_trans_req && !active_in) w_state_nxt = ST_PEND;
      // A new request while pending is illegal; keep holding rather than drop it.
      ST_PEND: if (active_in && readyout_in && !w_trans_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef AHB_BM_SEQ2NONSEQ_EN
  // Arbitration may have broken the burst, so a held SEQ restarts as an undefined-length INCR.
  assign w_held_trans = (r_trans == TRN_SEQ) ? TRN_NONSEQ : r_trans;
  assign w_held_burst = (r_trans == TRN_SEQ) ? BST_INCR   : r_burst;
`else
  assign w_held_trans = r_trans;
  assign w_held_burst = r_burst;
`endif

  always_comb begin
    sel_in     = HSELS;
    addr_in    = HADDRS;
    trans_in   = HTRANSS;
    write_in   = HWRITES;
    size_in    = HSIZES;
    burst_in   = HBURSTS;
    prot_in    = HPROTS;
    held_tran  = 1'b0;
    HREADYOUTS = readyout_in;
    HRESPS     = resp_in;
    if (r_state == ST_PEND) begin
      sel_in     = 1'b1;
      addr_in    = r_addr;
      trans_in   = w_held_trans;
      write_in   = r_write;
      size_in    = r_size;
      burst_in   = w_held_burst;
      prot_in    = r_prot;
      held_tran  = 1'b1;
      HREADYOUTS = 1'b0;
      HRESPS     = RSP_OKAY;
    end
  end

  // The master sees HREADY low while pending, so it must never present a new transfer then.
  a_no_req_while_pend : assert property (
    @(posedge HCLK) disable iff (!HRESETn) !((r_state == ST_PEND) && w_trans_req)
  );

endmodule

// File: tb/tb_cmsdk_ahb_bm_input_stage_si1.sv
// Directed self-checking bench for the SI1 bus-matrix input stage.
module tb_cmsdk_ahb_bm_input_stage_si1;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        active_in;
  logic        readyout_in;
  logic [1:0]  resp_in;
  logic        sel_in;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic        held_tran;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  int checks = 0;
  int errors = 0;

  cmsdk_ahb_bm_input_stage_si1 #(.ADDR_WIDTH(32)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HPROTS      (HPROTS),
    .HREADYS     (HREADYS),
    .active_in   (active_in),
    .readyout_in (readyout_in),
    .resp_in     (resp_in),
    .sel_in      (sel_in),
    .addr_in     (addr_in),
    .trans_in    (trans_in),
    .write_in    (write_in),
    .size_in     (size_in),
    .burst_in    (burst_in),
    .prot_in     (prot_in),
    .held_tran   (held_tran),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = '0; HBURSTS = '0; HPROTS = '0; HREADYS = 1'b1;
    active_in = 1'b1; readyout_in = 1'b1; resp_in = 2'b00;
    #1;
    check("rst_hreadyout", HREADYOUTS, 1);
    check("rst_hresp", HRESPS, 0);
    check("rst_held", held_tran, 0);
    check("rst_sel", sel_in, 0);
    tick(); tick();
    HRESETn = 1'b1;

    // Idle bus with select asserted: select passes through
    HSELS = 1'b1; #1;
    check("idle_sel", sel_in, 1);

    // Pass-through NONSEQ
    HADDRS = 32'h4000_0100; HTRANSS = 2'b10; active_in = 1'b1; #1;
    check("pt_addr", addr_in, 32'h4000_0100);
    check("pt_trans", trans_in, 2'b10);
    check("pt_ready", HREADYOUTS, 1);
    tick();
    HTRANSS = 2'b00; #1;
    check("pt_no_pend", held_tran, 0);
    check("pt_ready_after", HREADYOUTS, 1);

    // Held NONSEQ write: 1 request cycle with active low, then 3 more low, then release
    HADDRS = 32'h8000_0010; HWRITES = 1'b1; HTRANSS = 2'b10; HSIZES = 3'b010;
    HBURSTS = 3'b000; HPROTS = 4'b0011; active_in = 1'b0; #1;
    check("hold_req_cycle_held", held_tran, 0);
    tick();
    HADDRS = 32'hDEAD_0000; HWRITES = 1'b0; HTRANSS = 2'b00; HSELS = 1'b0;
    HREADYS = 1'b0; resp_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_held", held_tran, 1);
      check("hold_ready", HREADYOUTS, 0);
      check("hold_resp_okay", HRESPS, 0);
      check("hold_addr", addr_in, 32'h8000_0010);
      check("hold_sel", sel_in, 1);
      check("hold_write", write_in, 1);
      check("hold_trans", trans_in, 2'b10);
      tick();
    end
    active_in = 1'b1; readyout_in = 1'b1; #1;
    check("hold_release_held", held_tran, 1);
    check("hold_release_ready", HREADYOUTS, 0);
    tick();
    HREADYS = 1'b1; resp_in = 2'b00; #1;
    check("hold_cleared", held_tran, 0);
    check("hold_cleared_ready", HREADYOUTS, 1);
    check("hold_cleared_addr", addr_in, 32'hDEAD_0000);

    // Held SEQ for 2 cycles
    HSELS = 1'b1; HADDRS = 32'h8000_0014; HTRANSS = 2'b11; HBURSTS = 3'b011;
    HSIZES = 3'b010; HPROTS = 4'b1010; HWRITES = 1'b0; active_in = 1'b0; #1;
    tick();
    HTRANSS = 2'b00; HREADYS = 1'b0; HBURSTS = 3'b000; #1;
    for (int i = 0; i < 2; i++) begin
`ifdef AHB_BM_SEQ2NONSEQ_EN
      check("seq_trans", trans_in, 2'b10);
      check("seq_burst", burst_in, 3'b001);
`else
      check("seq_trans", trans_in, 2'b11);
      check("seq_burst", burst_in, 3'b011);
`endif
      check("seq_size", size_in, 3'b010);
      check("seq_prot", prot_in, 4'b1010);
      check("seq_addr", addr_in, 32'h8000_0014);
      if (i == 0) begin
        tick();
        active_in = 1'b1; #1;
      end
    end
    tick();
    HREADYS = 1'b1; #1;
    check("seq_cleared", held_tran, 0);

    // BUSY while idle passes through without pending
    HTRANSS = 2'b01; active_in = 1'b0; #1;
    check("busy_trans", trans_in, 2'b01);
    tick();
    #1;
    check("busy_no_pend", held_tran, 0);
    HTRANSS = 2'b00; active_in = 1'b1;

    // Two-cycle ERROR response passes through
    resp_in = 2'b01; readyout_in = 1'b0; #1;
    check("err1_resp", HRESPS, 2'b01);
    check("err1_ready", HREADYOUTS, 0);
    tick();
    readyout_in = 1'b1; #1;
    check("err2_resp", HRESPS, 2'b01);
    check("err2_ready", HREADYOUTS, 1);
    check("err2_held", held_tran, 0);
    tick();
    resp_in = 2'b00;

    // Reset while pending discards the held transfer
    HADDRS = 32'h1234_5678; HTRANSS = 2'b10; active_in = 1'b0; #1;
    tick();
    HTRANSS = 2'b00; HREADYS = 1'b0; #1;
    check("rstp_held_before", held_tran, 1);
    #2 HRESETn = 1'b0; #1;
    check("rstp_held", held_tran, 0);
    check("rstp_ready", HREADYOUTS, 1);
    tick();
    HRESETn = 1'b1; HREADYS = 1'b1;
    HADDRS = 32'h0000_0400; HTRANSS = 2'b10; active_in = 1'b1; #1;
    check("post_rst_addr", addr_in, 32'h0000_0400);
    check("post_rst_ready", HREADYOUTS, 1);
    tick();
    HTRANSS = 2'b00; #1;
    check("post_rst_no_pend", held_tran, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
